// File: rtl/cache_wb_axi_writer_pkg.sv
// Shared cache package: AXI3 encodings, default line geometry and the
// writeback FSM state type used by cache_wb_axi_writer.
package cache_wb_axi_writer_pkg;

    // Default line geometry: 20 + 6 + 6 = 32-bit physical address.
    localparam int DEF_CACHE_LINE_WIDTH = 6;   // log2 line bytes (64B)
    localparam int DEF_TAG_WIDTH        = 20;
    localparam int DEF_INDEX_WIDTH      = 6;
    localparam logic [3:0] DEF_AXI_ID   = 4'd1;

    // AXI3 encodings
    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [2:0] SIZE_4B         = 3'b010;
    localparam int         RESP_SLVERR_BIT = 1;   // BRESP[1] set => SLVERR/DECERR
    localparam logic [3:0] WSTRB_ALL       = 4'hF;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_AW   = 2'd1,
        WB_W    = 2'd2,
        WB_B    = 2'd3
    } wb_state_e;

endpackage

// File: rtl/cache_wb_axi_writer.sv
// Writeback engine: drains a dirty cache line word by word through the line
// read port and sends it as one AXI3 INCR write burst, then waits for BRESP.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   wb_req/wb_tag/wb_index  writeback request (sampled in IDLE only)
//   wb_busy/wb_done/wb_err  status; wb_done is a 1-cycle pulse, wb_err valid with it
//   line_roff/line_rdata    line read port; rdata is data[roff of previous cycle]
//   aw*/w*/b*               AXI3 write address, write data and response channels
module cache_wb_axi_writer
    import cache_wb_axi_writer_pkg::*;
#(
    parameter int         CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH,
    parameter int         TAG_WIDTH        = DEF_TAG_WIDTH,
    parameter int         INDEX_WIDTH      = DEF_INDEX_WIDTH,
    parameter int         OFFSET_WIDTH     = CACHE_LINE_WIDTH - 2,
    parameter logic [3:0] AXI_ID           = DEF_AXI_ID
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    wb_req,
    input  logic [TAG_WIDTH-1:0]    wb_tag,
    input  logic [INDEX_WIDTH-1:0]  wb_index,
    output logic                    wb_busy,
    output logic                    wb_done,
    output logic                    wb_err,

    output logic [OFFSET_WIDTH-1:0] line_roff,
    input  logic [31:0]             line_rdata,

    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    // Burst length follows the line geometry: one beat per 32-bit word.
    localparam logic [3:0]              AWLEN    = 4'((1 << OFFSET_WIDTH) - 1);
    localparam logic [OFFSET_WIDTH-1:0] LAST_PTR = '1;

    wb_state_e               state, state_nx;
    logic [OFFSET_WIDTH-1:0] ptr;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [INDEX_WIDTH-1:0]  index_q;

    logic accept, w_hs, b_hs;

    // bid is not checked and only the error bit of BRESP matters.
    logic unused_inputs;
    assign unused_inputs = ^{bid, bresp[0]};

    assign accept = (state == WB_IDLE) && wb_req;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;

    // Constant / latched channel fields.
    assign awid    = AXI_ID;
    assign awaddr  = {tag_q, index_q, {CACHE_LINE_WIDTH{1'b0}}};
    assign awlen   = AWLEN;
    assign awsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign wid     = AXI_ID;
    assign wstrb   = WSTRB_ALL;
    assign wdata   = line_rdata;
    assign wlast   = (ptr == LAST_PTR);
    assign wb_busy = (state != WB_IDLE);

    // Look one word ahead on a handshake so the read port output lines up
    // with the next beat; with wready low the address (and wdata) hold.
    // Outside W the port points at word 0, so it is ready on entering W.
    assign line_roff = (state == WB_W) ? (ptr + OFFSET_WIDTH'(w_hs)) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= WB_IDLE;
            ptr     <= '0;
            tag_q   <= '0;
            index_q <= '0;
            wb_done <= 1'b0;
            wb_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            wb_done <= b_hs;
            wb_err  <= b_hs && bresp[RESP_SLVERR_BIT];
            if (accept) begin
                tag_q   <= wb_tag;
                index_q <= wb_index;
                ptr     <= '0;
            end else if (w_hs) begin
                // Wraps LAST_PTR -> 0 on the final beat.
                ptr <= ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        unique case (state)
            WB_IDLE: if (wb_req) state_nx = WB_AW;
            WB_AW: begin
                awvalid = 1'b1;
                if (awready) state_nx = WB_W;
            end
            WB_W: begin
                wvalid = 1'b1;
                if (wready && wlast) state_nx = WB_B;
            end
            WB_B: begin
                bready = 1'b1;
                if (bvalid) state_nx = WB_IDLE;
            end
            default: state_nx = WB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_wb_axi_writer.sv
// Directed bench for cache_wb_axi_writer: a table of burst scenarios run
// through a cycle-level protocol model, plus hand-written reset and
// back-to-back sequences.
module tb_cache_wb_axi_writer;

    logic        clk, rst_n;
    logic        wb_req;
    logic [19:0] wb_tag;
    logic [5:0]  wb_index;
    logic        wb_busy, wb_done, wb_err;
    logic [3:0]  line_roff;
    logic [31:0] line_rdata;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int errors = 0;
    int checks = 0;

    cache_wb_axi_writer dut (
        .clk(clk), .rst_n(rst_n),
        .wb_req(wb_req), .wb_tag(wb_tag), .wb_index(wb_index),
        .wb_busy(wb_busy), .wb_done(wb_done), .wb_err(wb_err),
        .line_roff(line_roff), .line_rdata(line_rdata),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line storage model: registered read port.
    logic [31:0] mem [16];
    always @(posedge clk) line_rdata <= mem[line_roff];

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 16; i++) mem[i] = base + 32'(i);
    endtask

    typedef struct {
        logic [19:0] tag;
        logic [5:0]  idx;
        logic [31:0] base;
        int          aw_delay;
        int          b_delay;
        bit          wrand;
        logic [1:0]  bresp;
        bit          chain;      // hold wb_req so the next entry starts back-to-back
        logic [31:0] exp_addr;
        bit          exp_err;
    } vec_t;

    vec_t tbl [5];

    // Runs one burst. started=1 means the DUT is already in AW (chained).
    task automatic run_burst(input vec_t v, input bit started, input bit hold,
                             input logic [19:0] nxt_tag, input logic [5:0] nxt_idx);
        int  ph, beat, aw_cyc, b_cyc, w_cyc;
        bit  fin;
        ph = 0; beat = 0; aw_cyc = 0; b_cyc = 0; w_cyc = 0; fin = 0;
        fill(v.base);
        if (!started) begin
            @(negedge clk);
            wb_req = 1'b1; wb_tag = v.tag; wb_index = v.idx;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            #1;
            chk("idle_busy", wb_busy, 0);
            chk("idle_awvalid", awvalid, 0);
        end
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            wb_req   = hold;
            wb_tag   = nxt_tag;
            wb_index = nxt_idx;
            bid      = 4'($urandom_range(0, 15));
            awready  = (aw_cyc >= v.aw_delay);
            wready   = v.wrand ? 1'($urandom_range(0, 1)) : 1'b1;
            bvalid   = (ph == 2) && (b_cyc >= v.b_delay);
            bresp    = v.bresp;
            #1;
            if (ph == 3) begin
                chk("done_pulse", wb_done, 1);
                chk("done_err", wb_err, v.exp_err);
                chk("done_busy", wb_busy, 0);
                fin = 1;
            end else begin
                chk("awvalid", awvalid, ph == 0);
                chk("wvalid", wvalid, ph == 1);
                chk("bready", bready, ph == 2);
                chk("busy", wb_busy, 1);
                chk("early_done", wb_done, 0);
                chk("roff", line_roff, (ph == 1) ? 4'(beat + int'(wready)) : 4'd0);
                case (ph)
                    0: begin
                        chk("awaddr", awaddr, v.exp_addr);
                        chk("awlen", awlen, 15);
                        chk("awsize", awsize, 3'b010);
                        chk("awburst", awburst, 2'b01);
                        chk("awid", awid, 1);
                        aw_cyc++;
                        if (awready) ph = 1;
                    end
                    1: begin
                        chk("wdata", wdata, v.base + 32'(beat));
                        chk("wlast", wlast, beat == 15);
                        chk("wstrb", wstrb, 4'hF);
                        chk("wid", wid, 1);
                        w_cyc++;
                        if (wready) begin
                            if (beat == 15) ph = 2;
                            beat++;
                        end
                    end
                    default: begin
                        b_cyc++;
                        if (bvalid) ph = 3;
                    end
                endcase
            end
        end
        if (!fin) chk("burst_timeout", 0, 1);
        chk("beat_count", beat, 16);
        if (!v.wrand) chk("w_cycles", w_cyc, 16);
        // Cycle after the done pulse.
        @(negedge clk);
        wb_req = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        #1;
        chk("done_once", wb_done, 0);
        chk("err_clear", wb_err, 0);
        chk("post_awvalid", awvalid, hold);
        chk("post_busy", wb_busy, hold);
        if (hold) chk("chain_awaddr", awaddr, {nxt_tag, nxt_idx, 6'b0});
    endtask

    initial begin
        int  beat;
        bit  hit;
        logic [19:0] nt;
        logic [5:0]  ni;

        //      tag       idx    base          awd bd wr bresp chain exp_addr      err
        tbl[0] = '{20'hABCDE, 6'h05, 32'h1000_0000, 0, 0, 0, 2'b00, 0, 32'hABCDE140, 0};
        tbl[1] = '{20'h12345, 6'h2A, 32'h2000_0000, 0, 1, 1, 2'b01, 0, 32'h12345A80, 0};
        tbl[2] = '{20'hFFFFF, 6'h3F, 32'h3000_0000, 7, 0, 0, 2'b00, 0, 32'hFFFFFFC0, 0};
        tbl[3] = '{20'h00000, 6'h00, 32'h4000_0000, 2, 3, 0, 2'b10, 1, 32'h00000000, 1};
        tbl[4] = '{20'h5A5A5, 6'h11, 32'h5000_0000, 1, 2, 1, 2'b11, 0, 32'h5A5A5440, 1};

        rst_n = 1'b0; wb_req = 1'b0; wb_tag = '0; wb_index = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
        fill(32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", wb_busy, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_done", wb_done, 0);
        chk("rst_err", wb_err, 0);
        chk("rst_roff", line_roff, 0);
        chk("rst_awaddr", awaddr, 0);

        // Reset in the middle of the W burst, on beat 5.
        @(negedge clk);
        wb_req = 1'b1; wb_tag = 20'hABCDE; wb_index = 6'h05;
        fill(32'h7000_0000);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        wb_req = 1'b0;
        beat = 0; hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            #1;
            if (wvalid) begin
                if (beat == 5) begin
                    chk("rst_beat5_data", wdata, 32'h7000_0005);
                    rst_n = 1'b0;
                    hit = 1;
                end else begin
                    beat++;
                end
            end
            if (!hit) @(negedge clk);
        end
        if (!hit) chk("rst_beat5_timeout", 0, 1);
        @(negedge clk);
        #1;
        chk("midrst_wvalid", wvalid, 0);
        chk("midrst_busy", wb_busy, 0);
        chk("midrst_done", wb_done, 0);
        chk("midrst_awvalid", awvalid, 0);
        chk("midrst_roff", line_roff, 0);
        rst_n = 1'b1; awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_done2", wb_done, 0);
        chk("midrst_busy2", wb_busy, 0);

        // Table-driven bursts; a chained entry holds wb_req and presents the
        // next entry's tag/index throughout, which must not disturb it.
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].chain && i < 4) begin
                nt = tbl[i+1].tag; ni = tbl[i+1].idx;
            end else begin
                nt = 20'($urandom); ni = 6'($urandom);
            end
            run_burst(tbl[i], (i > 0) && tbl[i-1].chain, tbl[i].chain && (i < 4), nt, ni);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
